mandelbrot_frame_scheduler: RTL and testbench
=============================================

# mandelbrot_frame_scheduler

Sequences the mandelbrot engine across a full frame without per-pixel host involvement. It generates the complex coordinate for every pixel in row-major order and issues one run pulse per pixel. It captures the iteration count when the engine finishes and hands it to the framebuffer writer through a valid/ready port with a one-entry skid buffer. It sits between the configuration shift register (frame origin and step) and the engine/framebuffer pair, and replaces the top-level per-pixel state machine.

## Interface
- BITWIDTH, 11, fixed-point width of cr/ci coordinates and step
- CTRWIDTH, 4, width of engine ctr_out result forwarded to framebuffer
- H_PIXELS, 80, pixels per row
- V_PIXELS, 60, rows per frame
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  stop frame immediately, any state
- cr_origin  in  BITWIDTH  real part of pixel (0,0), two's complement
- ci_origin  in  BITWIDTH  imaginary part of pixel (0,0)
- step  in  BITWIDTH  coordinate increment per pixel/row, two's complement
- eng_run  out  1  one-cycle run pulse to engine
- eng_cr  out  BITWIDTH  real coordinate for current pixel
- eng_ci  out  BITWIDTH  imaginary coordinate for current pixel
- eng_running  in  1  engine busy flag
- eng_ctr  in  CTRWIDTH  engine result, valid on running falling edge
- out_valid  out  1  result available to framebuffer writer
- out_ready  in  1  writer accepts result this cycle
- out_data  out  CTRWIDTH  iteration count of oldest unaccepted pixel
- out_last  out  1  out_data belongs to final pixel of frame
- busy  out  1  high from start accept until frame_done or abort
- frame_done  out  1  one-cycle pulse when last pixel accepted

## Operation
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, STORE.
- IDLE: start=1 and eng_running=0 -> latch cr_origin/ci_origin/step into internal registers, x=0, y=0, busy=1, go ISSUE. start with eng_running=1 is ignored (not queued).
- ISSUE: eng_run=1 for exactly this cycle; go WAIT_HI.
- WAIT_HI: wait for eng_running=1, then go WAIT_LO.
- WAIT_LO: on eng_running=0, capture eng_ctr into result register; go STORE.
- STORE: if skid buffer empty, or full and out_ready=1 this cycle: move result in, set out_last = (x==H_PIXELS-1 && y==V_PIXELS-1), advance coordinates. Next state: IDLE after the last pixel, ISSUE otherwise. Otherwise hold in STORE.
- Coordinate advance: x<H_PIXELS-1 -> x+1, eng_cr+=step. Row end -> x=0, eng_cr=cr_origin latched, y+1, eng_ci+=step. All adds modulo 2^BITWIDTH; no saturation.
- eng_cr/eng_ci stay constant from ISSUE through STORE.
- Skid buffer: out_valid clears on out_valid&&out_ready unless refilled the same cycle. Simultaneous accept+refill keeps out_valid=1 with new data.
- frame_done=1 and busy=0 the cycle after out_valid&&out_ready&&out_last.
- abort: next cycle state=IDLE, busy=0, out_valid=0, eng_run=0, no frame_done. An in-flight engine run is abandoned. The next start waits for eng_running=0 through the IDLE rule.
- Configuration inputs may change mid-frame without effect; they are latched only at start.

## Timing
- Reset values: eng_run=0, eng_cr=0, eng_ci=0, out_valid=0, out_data=0, out_last=0, busy=0, frame_done=0, state=IDLE.
- start accepted at edge N -> eng_run high in cycle N+1, with eng_cr=cr_origin and eng_ci=ci_origin.
- Engine falling edge seen at edge M -> out_valid high at M+2 (capture, then store) when the buffer is free.
- Per-pixel overhead beyond engine time: 3 cycles (ISSUE, WAIT_HI entry, STORE).
- reset and abort both asserted: reset wins; outcome is identical.
- Single outstanding engine run at all times; no eng_run while in WAIT_HI, WAIT_LO or STORE.

## Structure
- Package mandelbrot_pkg: state enum (IDLE, ISSUE, WAIT_HI, WAIT_LO, STORE); localparams for x/y widths ($clog2 of H_PIXELS/V_PIXELS).
- Sub-module mandelbrot_coord_gen: holds x, y, eng_cr, eng_ci. Inputs: load, advance. Outputs: last_pixel. The scheduler FSM and skid buffer stay in the top module.

## Test plan
- H=4, V=2, origin (-8,-4), step 3, behavioural engine 5 cycles/pixel -> 8 results in order. eng_cr sequence -8,-5,-2,1 per row; eng_ci -4 then -1. out_last only on pixel 8; one frame_done.
- out_ready held 0 for 20 cycles mid-frame -> scheduler stalls in STORE after the buffer fills. No result is lost or duplicated, and eng_run does not fire during the stall.
- origin cr=1023 (max positive, BITWIDTH=11), step 1 -> second pixel eng_cr = -1024 (wrap), no error.
- abort asserted during WAIT_LO of pixel 3 -> busy=0 and out_valid=0 next cycle, no frame_done. start while eng_running=1 is ignored; start after eng_running falls restarts at pixel 0.
- start pulsed while busy -> ignored; frame completes with exactly H*V results.
- reset asserted mid-frame with out_valid=1 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types and sizing helpers for the mandelbrot frame scheduler.
// Counter widths are derived from the frame geometry so odd resolutions still fit.
package mandelbrot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    STORE   = 3'd4
  } state_t;

  localparam int H_PIXELS_DEFAULT = 80;
  localparam int V_PIXELS_DEFAULT = 60;

  // A one-pixel dimension still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int X_WIDTH = cnt_width(H_PIXELS_DEFAULT);
  localparam int Y_WIDTH = cnt_width(V_PIXELS_DEFAULT);

endpackage

// File: rtl/mandelbrot_coord_gen.sv
// Raster coordinate generator: walks x/y in row-major order and keeps the
// complex coordinate of the current pixel, accumulated from the latched origin/step.
module mandelbrot_coord_gen
  import mandelbrot_pkg::*;
#(
  parameter int BITWIDTH = 11,
  parameter int H_PIXELS = H_PIXELS_DEFAULT,
  parameter int V_PIXELS = V_PIXELS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                advance,
  input  logic [BITWIDTH-1:0] cr_origin,
  input  logic [BITWIDTH-1:0] ci_origin,
  input  logic [BITWIDTH-1:0] step,
  output logic [BITWIDTH-1:0] eng_cr,
  output logic [BITWIDTH-1:0] eng_ci,
  output logic                last_pixel
);

  localparam int XW = cnt_width(H_PIXELS);
  localparam int YW = cnt_width(V_PIXELS);
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [BITWIDTH-1:0] cr_base;
  logic [BITWIDTH-1:0] step_q;

  // Sums wrap modulo 2^BITWIDTH on purpose; the engine treats them as two's complement.
  always_ff @(posedge clk) begin
    if (reset) begin
      x       <= '0;
      y       <= '0;
      eng_cr  <= '0;
      eng_ci  <= '0;
      cr_base <= '0;
      step_q  <= '0;
    end else if (load) begin
      x       <= '0;
      y       <= '0;
      eng_cr  <= cr_origin;
      eng_ci  <= ci_origin;
      cr_base <= cr_origin;
      step_q  <= step;
    end else if (advance) begin
      if (x != X_LAST) begin
        x      <= x + 1'b1;
        eng_cr <= eng_cr + step_q;
      end else begin
        x      <= '0;
        eng_cr <= cr_base;
        y      <= y + 1'b1;
        eng_ci <= eng_ci + step_q;
      end
    end
  end

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/mandelbrot_frame_scheduler.sv
// Frame scheduler: issues one engine run per pixel, captures each iteration count
// and presents it to the framebuffer writer through a one-entry skid buffer.
module mandelbrot_frame_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int BITWIDTH = 11,
  parameter int CTRWIDTH = 4,
  parameter int H_PIXELS = H_PIXELS_DEFAULT,
  parameter int V_PIXELS = V_PIXELS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [BITWIDTH-1:0] cr_origin,
  input  logic [BITWIDTH-1:0] ci_origin,
  input  logic [BITWIDTH-1:0] step,
  output logic                eng_run,
  output logic [BITWIDTH-1:0] eng_cr,
  output logic [BITWIDTH-1:0] eng_ci,
  input  logic                eng_running,
  input  logic [CTRWIDTH-1:0] eng_ctr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRWIDTH-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                frame_done,
  output state_t              state
);

  // Output handshake: a result transfers on every rising edge where out_valid and
  // out_ready are both high; out_valid/out_data/out_last hold steady until then.

  logic                load;
  logic                store_ok;
  logic                last_pixel;
  logic [CTRWIDTH-1:0] result_q;

  // A new frame needs the engine idle and the previous frame fully drained.
  assign load     = (state == IDLE) && start && !eng_running && !busy && !abort;
  assign store_ok = (state == STORE) && (!out_valid || out_ready) && !abort;

  mandelbrot_coord_gen #(
    .BITWIDTH (BITWIDTH),
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS)
  ) u_coord_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .advance    (store_ok),
    .cr_origin  (cr_origin),
    .ci_origin  (ci_origin),
    .step       (step),
    .eng_cr     (eng_cr),
    .eng_ci     (eng_ci),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      eng_run    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      result_q   <= '0;
    end else if (abort) begin
      // Any in-flight engine run is simply abandoned.
      state      <= IDLE;
      eng_run    <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      eng_run    <= 1'b0;
      frame_done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        if (out_last) begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
        end
      end
      case (state)
        IDLE: begin
          if (load) begin
            busy    <= 1'b1;
            eng_run <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_HI;
        WAIT_HI: begin
          if (eng_running) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!eng_running) begin
            result_q <= eng_ctr;
            state    <= STORE;
          end
        end
        STORE: begin
          // A refill in the same cycle as an accept overrides the clear above.
          if (store_ok) begin
            out_valid <= 1'b1;
            out_data  <= result_q;
            out_last  <= last_pixel;
            if (last_pixel) begin
              state <= IDLE;
            end else begin
              eng_run <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_frame_scheduler.sv
// Bench for mandelbrot_frame_scheduler on a 4x2 frame with a behavioural engine
// whose result is a hash of the coordinate it was given.
module tb_mandelbrot_frame_scheduler;
  import mandelbrot_pkg::*;

  localparam int BW   = 11;
  localparam int CW   = 4;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;
  localparam int OW   = 2 * BW + CW + 5;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [BW-1:0] cr_origin, ci_origin, step;
  logic          eng_run;
  logic [BW-1:0] eng_cr, eng_ci;
  logic          eng_running = 1'b0;
  logic [CW-1:0] eng_ctr = '0;
  logic          out_valid, out_ready;
  logic [CW-1:0] out_data;
  logic          out_last, busy, frame_done;
  state_t        state;

  int n_vec, n_err;

  mandelbrot_frame_scheduler #(
    .BITWIDTH (BW), .CTRWIDTH (CW), .H_PIXELS (H), .V_PIXELS (V)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .abort (abort),
    .cr_origin (cr_origin), .ci_origin (ci_origin), .step (step),
    .eng_run (eng_run), .eng_cr (eng_cr), .eng_ci (eng_ci),
    .eng_running (eng_running), .eng_ctr (eng_ctr),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .out_last (out_last), .busy (busy), .frame_done (frame_done), .state (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // ---------------- behavioural engine ----------------
  int eng_lat = 5;
  int eng_left = 0;

  function automatic logic [CW-1:0] ref_ctr(input logic [BW-1:0] cr, input logic [BW-1:0] ci);
    logic [BW-1:0] m;
    m = cr + (ci * 3) + (cr >> 4);
    return m[CW-1:0] ^ m[2*CW-1:CW];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      eng_running <= 1'b0;
      eng_left    <= 0;
    end else if (eng_running) begin
      if (eng_left <= 1) eng_running <= 1'b0;
      eng_left <= eng_left - 1;
    end else if (eng_run) begin
      eng_running <= 1'b1;
      eng_left    <= eng_lat;
      eng_ctr     <= ref_ctr(eng_cr, eng_ci);
    end
  end

  // ---------------- monitors ----------------
  logic [CW:0]     got_q[$];
  logic [2*BW-1:0] run_q[$];
  int done_cnt, overlap_cnt;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (eng_run) begin
        run_q.push_back({eng_cr, eng_ci});
        if (eng_running) overlap_cnt++;
      end
      if (frame_done) done_cnt++;
    end
  end

  // ---------------- reference model ----------------
  logic [CW:0]     exp_q[$];
  logic [2*BW-1:0] exp_run_q[$];

  task automatic build_model(input logic [BW-1:0] cr0, input logic [BW-1:0] ci0,
                             input logic [BW-1:0] st);
    exp_q.delete();
    exp_run_q.delete();
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        logic [BW-1:0] cr, ci;
        cr = cr0 + BW'(x) * st;
        ci = ci0 + BW'(y) * st;
        exp_run_q.push_back({cr, ci});
        exp_q.push_back({(x == H - 1 && y == V - 1), ref_ctr(cr, ci)});
      end
    end
  endtask

  // ---------------- driver ----------------
  int     stall_runs;
  state_t stall_state;
  logic   stall_valid;

  task automatic drive_frame(input logic [BW-1:0] cr0, input logic [BW-1:0] ci0,
                             input logic [BW-1:0] st, input int ready_pct,
                             input bit poke_start, input int stall_at,
                             output bit first_ok, output bit timed_out);
    int cyc;
    bit stalled;
    got_q.delete();
    run_q.delete();
    done_cnt = 0;
    stalled  = 0;
    build_model(cr0, ci0, st);
    cr_origin = cr0; ci_origin = ci0; step = st;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_ok = (eng_run === 1'b1) && (eng_cr === cr0) && (eng_ci === ci0) && (busy === 1'b1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      cr_origin = BW'($urandom); ci_origin = BW'($urandom); step = BW'($urandom);
      start     = poke_start && busy && ($urandom_range(2) == 0);
      out_ready = ($urandom_range(99) < ready_pct);
      if (stall_at >= 0 && !stalled && got_q.size() >= stall_at) begin
        stalled = 1; stall_runs = 0; out_ready = 1'b0; start = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          if (i >= 10 && eng_run) stall_runs++;
        end
        stall_state = state;
        stall_valid = out_valid;
        out_ready   = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    timed_out = (done_cnt == 0);
    repeat (12) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [OW-1:0] obs;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {eng_run, eng_cr, eng_ci, out_valid, out_data, out_last, busy, frame_done};
    n_vec++;
    if (obs !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", obs);
    end
    n_vec++;
    if (state !== IDLE) begin
      n_err++; $display("FAIL reset_state got %0d want %0d", state, IDLE);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    bit first_ok, timed_out;
    eng_lat = 5;
    drive_frame(-11'sd8, -11'sd4, 11'd3, 100, 0, -1, first_ok, timed_out);
    n_vec++;
    if (!first_ok) begin
      n_err++; $display("FAIL basic_first_run got run=%0b cr=%h want run=1 cr=%h", eng_run, eng_cr, 11'h7f8);
    end
    n_vec++;
    if (timed_out || got_q.size() != NPIX || run_q.size() != NPIX) begin
      n_err++; $display("FAIL basic_count got %0d/%0d want %0d", got_q.size(), run_q.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < got_q.size() && i < run_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i] || run_q[i] !== exp_run_q[i]) begin
        n_err++; $display("FAIL basic_pixel%0d got %h/%h want %h/%h", i, got_q[i], run_q[i], exp_q[i], exp_run_q[i]);
      end
    end
    n_vec++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_done got done=%0d busy=%0b want 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_stall();
    bit first_ok, timed_out;
    eng_lat = 5;
    drive_frame(BW'($urandom), BW'($urandom), BW'($urandom), 100, 0, 3, first_ok, timed_out);
    n_vec++;
    if (stall_state !== STORE || stall_valid !== 1'b1 || stall_runs !== 0) begin
      n_err++; $display("FAIL stall_hold got state=%0d valid=%0b runs=%0d want %0d/1/0", stall_state, stall_valid, stall_runs, STORE);
    end
    n_vec++;
    if (timed_out || got_q.size() != NPIX || run_q.size() != NPIX) begin
      n_err++; $display("FAIL stall_count got %0d/%0d want %0d", got_q.size(), run_q.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < got_q.size() && i < run_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i] || run_q[i] !== exp_run_q[i]) begin
        n_err++; $display("FAIL stall_pixel%0d got %h/%h want %h/%h", i, got_q[i], run_q[i], exp_q[i], exp_run_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit first_ok, timed_out;
    logic [2*BW-1:0] second;
    eng_lat = 2;
    drive_frame(11'd1023, 11'd0, 11'd1, 70, 0, -1, first_ok, timed_out);
    second = (run_q.size() > 1) ? run_q[1] : '0;
    n_vec++;
    if (run_q.size() < 2 || second[2*BW-1:BW] !== 11'h400) begin
      n_err++; $display("FAIL wrap_cr got %h want %h", second[2*BW-1:BW], 11'h400);
    end
    n_vec++;
    if (timed_out || got_q.size() != NPIX || done_cnt !== 1) begin
      n_err++; $display("FAIL wrap_count got %0d done=%0d want %0d done=1", got_q.size(), done_cnt, NPIX);
    end
    for (int i = 0; i < NPIX && i < got_q.size() && i < run_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i] || run_q[i] !== exp_run_q[i]) begin
        n_err++; $display("FAIL wrap_pixel%0d got %h/%h want %h/%h", i, got_q[i], run_q[i], exp_q[i], exp_run_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    int cyc;
    bit first_ok, timed_out;
    logic [BW-1:0] cr0, ci0, st;
    eng_lat = 5;
    cr0 = BW'($urandom); ci0 = BW'($urandom); st = BW'($urandom);
    got_q.delete(); run_q.delete(); done_cnt = 0;
    cr_origin = cr0; ci_origin = ci0; step = st; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(run_q.size() == 3 && state == WAIT_LO) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (cyc >= 500) begin
      n_err++; $display("FAIL abort_reach_wait_lo got timeout runs=%0d want 3", run_q.size());
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || state !== IDLE || eng_run !== 1'b0) begin
      n_err++; $display("FAIL abort_clear got busy=%0b valid=%0b state=%0d want 0/0/%0d", busy, out_valid, state, IDLE);
    end
    // Engine still busy with the abandoned pixel: this start must be dropped.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || state !== IDLE) begin
      n_err++; $display("FAIL abort_start_ignored got busy=%0b state=%0d want 0/%0d", busy, state, IDLE);
    end
    cyc = 0;
    while (eng_running && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_no_done got done=%0d busy=%0b want 0/0", done_cnt, busy);
    end
    drive_frame(cr0, ci0, st, 80, 0, -1, first_ok, timed_out);
    n_vec++;
    if (timed_out || !first_ok || got_q.size() != NPIX || run_q.size() != NPIX) begin
      n_err++; $display("FAIL abort_restart got %0d/%0d first=%0b want %0d first=1", got_q.size(), run_q.size(), first_ok, NPIX);
    end
    for (int i = 0; i < NPIX && i < got_q.size() && i < run_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i] || run_q[i] !== exp_run_q[i]) begin
        n_err++; $display("FAIL abort_pixel%0d got %h/%h want %h/%h", i, got_q[i], run_q[i], exp_q[i], exp_run_q[i]);
      end
    end
  endtask

  // Several random frames, with start pulsed while busy to show it is ignored.
  task automatic test_back_to_back();
    bit first_ok, timed_out;
    for (int f = 0; f < 4; f++) begin
      eng_lat = $urandom_range(1, 6);
      drive_frame(BW'($urandom), BW'($urandom), BW'($urandom), $urandom_range(40, 100), 1, -1,
                  first_ok, timed_out);
      n_vec++;
      if (timed_out || got_q.size() != NPIX || run_q.size() != NPIX || done_cnt !== 1) begin
        n_err++; $display("FAIL b2b%0d_count got %0d/%0d done=%0d want %0d done=1", f, got_q.size(), run_q.size(), done_cnt, NPIX);
      end
      for (int i = 0; i < NPIX && i < got_q.size() && i < run_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i] || run_q[i] !== exp_run_q[i]) begin
          n_err++; $display("FAIL b2b%0d_pixel%0d got %h/%h want %h/%h", f, i, got_q[i], run_q[i], exp_q[i], exp_run_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [OW-1:0] obs;
    eng_lat = 3;
    cr_origin = BW'($urandom); ci_origin = BW'($urandom); step = BW'($urandom);
    start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_setup got valid=%0b want 1", out_valid);
    end
    reset = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    obs = {eng_run, eng_cr, eng_ci, out_valid, out_data, out_last, busy, frame_done};
    n_vec++;
    if (obs !== '0 || state !== IDLE) begin
      n_err++; $display("FAIL reset_mid_outputs got %h state=%0d want 0 state=%0d", obs, state, IDLE);
    end
    reset = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0; n_err = 0; done_cnt = 0; overlap_cnt = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cr_origin = '0; ci_origin = '0; step = '0;
    test_reset();
    test_basic_frame();
    test_stall();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    n_vec++;
    if (overlap_cnt !== 0) begin
      n_err++; $display("FAIL single_outstanding got %0d overlapping runs want 0", overlap_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
